// File: rtl/axi4_burst_sram.sv
// rtl/axi4_burst_sram.sv - AXI4 burst slave SRAM, one transaction at a time
module axi4_burst_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] awaddr_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  awid_i,
  input  logic [7:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [31:0] araddr_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  input  logic [3:0]  arid_i,
  input  logic [7:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [7:0]  LAT_LAST   = 8'(RD_LAT - 1);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLV   = 2'b10;
  localparam logic [1:0]  RESP_DEC   = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [3:0]  id_q;
  logic [7:0]  len_q, cnt_q, lat_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q, err_q;
  logic        bad_q;
  logic        awready_q, arready_q, wready_q, bvalid_q, rvalid_q, rlast_q;
  logic [3:0]  bid_q, rid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]   off, next_addr;
  logic          in_range, last_beat, present_beat, mem_we;
  logic [AW-1:0] word_idx;
  logic [1:0]    beat_resp, w_err, err_d;

  assign off       = addr_q - BASE_ADDR;
  assign in_range  = (addr_q >= BASE_ADDR) && ({1'b0, off} < SPAN_BYTES);
  assign word_idx  = off[AW+1:2];
  assign next_addr = (burst_q == 2'b01) ? addr_q + (32'd1 << size_q) : addr_q;
  assign last_beat = (cnt_q == len_q);
  // Illegal size/burst dominates; otherwise an out-of-window beat decodes as DECERR.
  assign beat_resp = bad_q ? RESP_SLV : (!in_range ? RESP_DEC : RESP_OKAY);
  assign present_beat = ((state_q == RD_WAIT) && (lat_q == LAT_LAST)) ||
                        ((state_q == RD_DATA) && rready_i && !rlast_q);
  assign mem_we = (state_q == WR_DATA) && wready_q && wvalid_i && (beat_resp == RESP_OKAY);

  // Per-beat write response: a wlast mismatch escalates to SLVERR, then keep the worst seen.
  always_comb begin
    w_err = beat_resp;
    if ((wlast_i != last_beat) && (w_err < RESP_SLV)) w_err = RESP_SLV;
    err_d = (w_err > err_q) ? w_err : err_q;
  end

  // Byte-masked memory write; storage deliberately has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= '0;
      bad_q     <= 1'b0;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      bid_q     <= '0;
      rid_q     <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arready_q && arvalid_i) begin
            addr_q    <= araddr_i;
            id_q      <= arid_i;
            len_q     <= arlen_i;
            size_q    <= arsize_i;
            burst_q   <= arburst_i;
            bad_q     <= (arsize_i > 3'd2) || arburst_i[1];
            cnt_q     <= '0;
            lat_q     <= '0;
            err_q     <= '0;
            arready_q <= 1'b0;
            awready_q <= 1'b0;
            state_q   <= RD_WAIT;
          end else if (awready_q && awvalid_i) begin
            addr_q    <= awaddr_i;
            id_q      <= awid_i;
            len_q     <= awlen_i;
            size_q    <= awsize_i;
            burst_q   <= awburst_i;
            bad_q     <= (awsize_i > 3'd2) || awburst_i[1];
            cnt_q     <= '0;
            err_q     <= '0;
            arready_q <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            state_q   <= WR_DATA;
          end else begin
            arready_q <= 1'b1;
            awready_q <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (lat_q == LAT_LAST) state_q <= RD_DATA;
          else                   lat_q   <= lat_q + 8'd1;
        end
        RD_DATA: begin
          if (rready_i && rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            awready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        WR_DATA: begin
          if (wvalid_i) begin
            err_q <= err_d;
            if (last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= err_d;
              bid_q    <= id_q;
              state_q  <= WR_RESP;
            end else begin
              cnt_q  <= cnt_q + 8'd1;
              addr_q <= next_addr;
            end
          end
        end
        WR_RESP: begin
          if (bready_i) begin
            bvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            awready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Load the next read beat; shared by the first beat and back-to-back beats.
      if (present_beat) begin
        rvalid_q <= 1'b1;
        rid_q    <= id_q;
        rresp_q  <= beat_resp;
        rdata_q  <= (beat_resp == RESP_OKAY) ? mem_q[word_idx] : 32'd0;
        rlast_q  <= last_beat;
        cnt_q    <= cnt_q + 8'd1;
        addr_q   <= next_addr;
      end
    end
  end

  assign awready_o = awready_q;
  assign arready_o = arready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bid_o     = bid_q;
  assign bresp_o   = bresp_q;
  assign rvalid_o  = rvalid_q;
  assign rid_o     = rid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rlast_o   = rlast_q;

endmodule

// File: tb/tb_axi4_burst_sram.sv
// tb/tb_axi4_burst_sram.sv - directed self-checking bench for axi4_burst_sram
module tb_axi4_burst_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic        awvalid = 0, wlast = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [3:0]  awid = '0, wstrb = '0, arid = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = 3'd2, arsize = 3'd2;
  logic [1:0]  awburst = 2'b01, arburst = 2'b01;
  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_burst_sram #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4096), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready), .awid_i(awid),
    .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready), .arid_i(arid),
    .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid),
    .rready_i(rready)
  );

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] id, input logic [31:0] d [8],
                          input logic [3:0] strb, input int last_at,
                          output logic [1:0] resp, output logic [3:0] rbid);
    int t;
    awaddr = addr; awlen = len; awburst = burst; awsize = size; awid = id; awvalid = 1;
    t = 0;
    while (!awready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) begin checks++; errors++; $display("FAIL aw_timeout got awready=%b want 1", awready); end
    @(posedge clk); #1; awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = d[i]; wstrb = strb; wlast = (i == last_at); wvalid = 1;
      t = 0;
      while (!wready && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) begin checks++; errors++; $display("FAIL w_timeout got wready=%b want 1", wready); end
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0; bready = 1;
    t = 0;
    while (!bvalid && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) begin checks++; errors++; $display("FAIL b_timeout got bvalid=%b want 1", bvalid); end
    resp = bresp; rbid = bid;
    @(posedge clk); #1; bready = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [3:0] id, input int mode,
                         output logic [31:0] rd [8], output logic [1:0] rr [8], output logic rl [8],
                         output logic [3:0] ri [8], output int n, output int lat, output int cyc,
                         output int viol, output logic post_rvalid);
    int t;
    logic [38:0] snap;
    logic go, v, tog;
    for (int i = 0; i < 8; i++) begin rd[i] = '0; rr[i] = '0; rl[i] = 0; ri[i] = '0; end
    araddr = addr; arlen = len; arburst = burst; arsize = size; arid = id; arvalid = 1;
    t = 0;
    while (!arready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) begin checks++; errors++; $display("FAIL ar_timeout got arready=%b want 1", arready); end
    @(posedge clk); #1; arvalid = 0;
    lat = 0;
    while (!rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    n = 0; cyc = 0; viol = 0; tog = 0;
    while (n < 8 && cyc < 100) begin
      go = (mode == 0) || !tog;
      rready = go;
      snap = {rdata, rresp, rlast, rid};
      v = rvalid;
      @(posedge clk); #1; cyc++; tog = !tog;
      if (v && go) begin
        rd[n] = snap[38:7]; rr[n] = snap[6:5]; rl[n] = snap[4]; ri[n] = snap[3:0];
        n++;
        if (snap[4]) break;
      end else if (v) begin
        if (!rvalid || ({rdata, rresp, rlast, rid} !== snap)) viol++;
      end
    end
    rready = 0;
    post_rvalid = rvalid;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b0) begin errors++;
      $display("FAIL reset_ctrl got %b want 000000", {arready, awready, wready, rvalid, bvalid, rlast}); end
    checks++; if ({rdata, rid, rresp, bid, bresp} !== 44'd0) begin errors++;
      $display("FAIL reset_data got %h want 0", {rdata, rid, rresp, bid, bresp}); end
    rst = 0;
    #1;
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL reset_arready_before_edge got %b want 0", arready); end
    @(posedge clk); #1;
    checks++; if ({arready, awready} !== 2'b11) begin errors++; $display("FAIL reset_ready_rise got %b want 11", {arready, awready}); end
  endtask

  task automatic test_single_read();
    logic [31:0] d [8]; logic [31:0] rd [8]; logic [1:0] rr [8]; logic rl [8]; logic [3:0] ri [8];
    logic [1:0] resp; logic [3:0] b; int n, lat, cyc, viol; logic pv;
    d = '{default: 32'd0}; d[0] = 32'hDEAD_BEEF;
    do_write(32'h8000_0010, 8'd0, 2'b01, 3'd2, 4'd1, d, 4'hF, 0, resp, b);
    do_read(32'h8000_0010, 8'd0, 2'b01, 3'd2, 4'd3, 0, rd, rr, rl, ri, n, lat, cyc, viol, pv);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency got %0d want 2", lat); end
    checks++; if (rd[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata got %h want deadbeef", rd[0]); end
    checks++; if ({ri[0], rl[0], rr[0]} !== {4'd3, 1'b1, 2'b00}) begin errors++;
      $display("FAIL single_rid_rlast_rresp got %h/%b/%b want 3/1/00", ri[0], rl[0], rr[0]); end
    checks++; if (n !== 1) begin errors++; $display("FAIL single_beats got %0d want 1", n); end
  endtask

  task automatic test_burst_write_read();
    logic [31:0] d [8]; logic [31:0] rd [8]; logic [1:0] rr [8]; logic rl [8]; logic [3:0] ri [8];
    logic [1:0] resp; logic [3:0] b; int n, lat, cyc, viol; logic pv;
    d = '{default: 32'd0}; d[0] = 32'd1; d[1] = 32'd2; d[2] = 32'd3; d[3] = 32'd4;
    do_write(32'h8000_0100, 8'd3, 2'b01, 3'd2, 4'd5, d, 4'hF, 3, resp, b);
    checks++; if ({b, resp} !== {4'd5, 2'b00}) begin errors++; $display("FAIL burst_wr_bresp got bid=%h bresp=%b want 5/00", b, resp); end
    do_read(32'h8000_0100, 8'd3, 2'b01, 3'd2, 4'd5, 0, rd, rr, rl, ri, n, lat, cyc, viol, pv);
    for (int i = 0; i < 4; i++) begin
      checks++; if ({rd[i], rl[i], rr[i]} !== {32'(i + 1), (i == 3), 2'b00}) begin errors++;
        $display("FAIL burst_rd_beat%0d got %h last=%b resp=%b want %h last=%b", i, rd[i], rl[i], rr[i], i + 1, i == 3); end
    end
    checks++; if ({n, cyc} !== {32'd4, 32'd4}) begin errors++; $display("FAIL burst_b2b got beats=%0d cycles=%0d want 4/4", n, cyc); end
  endtask

  task automatic test_rready_throttle();
    logic [31:0] rd [8]; logic [1:0] rr [8]; logic rl [8]; logic [3:0] ri [8];
    int n, lat, cyc, viol; logic pv;
    do_read(32'h8000_0100, 8'd3, 2'b01, 3'd2, 4'd2, 1, rd, rr, rl, ri, n, lat, cyc, viol, pv);
    checks++; if (n !== 4) begin errors++; $display("FAIL throttle_beats got %0d want 4", n); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL throttle_stable got %0d changes want 0", viol); end
    checks++; if ({rd[0], rd[1], rd[2], rd[3]} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin errors++;
      $display("FAIL throttle_data got %h %h %h %h want 1 2 3 4", rd[0], rd[1], rd[2], rd[3]); end
    checks++; if ({pv, arready} !== 2'b01) begin errors++; $display("FAIL throttle_end got rvalid=%b arready=%b want 0/1", pv, arready); end
  endtask

  task automatic test_wstrb();
    logic [31:0] d [8]; logic [31:0] rd [8]; logic [1:0] rr [8]; logic rl [8]; logic [3:0] ri [8];
    logic [1:0] resp; logic [3:0] b; int n, lat, cyc, viol; logic pv;
    d = '{default: 32'd0}; d[0] = 32'h1122_3344;
    do_write(32'h8000_0200, 8'd0, 2'b01, 3'd2, 4'd0, d, 4'hF, 0, resp, b);
    d[0] = 32'hAABB_CCDD;
    do_write(32'h8000_0200, 8'd0, 2'b01, 3'd2, 4'd0, d, 4'b0101, 0, resp, b);
    do_read(32'h8000_0200, 8'd0, 2'b01, 3'd2, 4'd0, 0, rd, rr, rl, ri, n, lat, cyc, viol, pv);
    checks++; if (rd[0] !== 32'h11BB_33DD) begin errors++; $display("FAIL wstrb_merge got %h want 11bb33dd", rd[0]); end
  endtask

  task automatic test_errors();
    logic [31:0] d [8]; logic [31:0] rd [8]; logic [1:0] rr [8]; logic rl [8]; logic [3:0] ri [8];
    logic [1:0] resp; logic [3:0] b; int n, lat, cyc, viol; logic pv;
    do_read(32'h7000_0000, 8'd0, 2'b01, 3'd2, 4'd1, 0, rd, rr, rl, ri, n, lat, cyc, viol, pv);
    checks++; if ({rr[0], rd[0]} !== {2'b11, 32'd0}) begin errors++; $display("FAIL decerr_low got resp=%b data=%h want 11/0", rr[0], rd[0]); end
    do_read(32'h8000_3FFC, 8'd1, 2'b01, 3'd2, 4'd1, 0, rd, rr, rl, ri, n, lat, cyc, viol, pv);
    checks++; if ({rr[0], rr[1], rd[1], rl[1]} !== {2'b00, 2'b11, 32'd0, 1'b1}) begin errors++;
      $display("FAIL decerr_runoff got resp0=%b resp1=%b data1=%h last1=%b want 00/11/0/1", rr[0], rr[1], rd[1], rl[1]); end
    d = '{default: 32'd0}; d[0] = 32'hCAFE_0001; d[1] = 32'hCAFE_0002;
    do_write(32'h8000_0300, 8'd1, 2'b01, 3'd2, 4'd0, d, 4'hF, 1, resp, b);
    d[0] = 32'hFFFF_FFFF; d[1] = 32'hFFFF_FFFF;
    do_write(32'h8000_0300, 8'd1, 2'b10, 3'd2, 4'd7, d, 4'hF, 1, resp, b);
    checks++; if ({b, resp} !== {4'd7, 2'b10}) begin errors++; $display("FAIL slverr_burst got bid=%h bresp=%b want 7/10", b, resp); end
    do_read(32'h8000_0300, 8'd1, 2'b01, 3'd2, 4'd0, 0, rd, rr, rl, ri, n, lat, cyc, viol, pv);
    checks++; if ({rd[0], rd[1]} !== {32'hCAFE_0001, 32'hCAFE_0002}) begin errors++;
      $display("FAIL slverr_no_write got %h %h want cafe0001 cafe0002", rd[0], rd[1]); end
    do_read(32'h8000_0300, 8'd0, 2'b01, 3'd3, 4'd0, 0, rd, rr, rl, ri, n, lat, cyc, viol, pv);
    checks++; if ({rr[0], rd[0]} !== {2'b10, 32'd0}) begin errors++; $display("FAIL slverr_size got resp=%b data=%h want 10/0", rr[0], rd[0]); end
    d[0] = 32'h55; d[1] = 32'h66;
    do_write(32'h8000_0400, 8'd1, 2'b01, 3'd2, 4'd0, d, 4'hF, 0, resp, b);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL wlast_early got bresp=%b want 10", resp); end
    do_read(32'h8000_0400, 8'd1, 2'b01, 3'd2, 4'd0, 0, rd, rr, rl, ri, n, lat, cyc, viol, pv);
    checks++; if ({rd[0], rd[1]} !== {32'h55, 32'h66}) begin errors++; $display("FAIL wlast_early_data got %h %h want 55 66", rd[0], rd[1]); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d [8]; logic [31:0] rd [8]; logic [1:0] rr [8]; logic rl [8]; logic [3:0] ri [8];
    logic [1:0] resp; logic [3:0] b; int n, lat, cyc, viol, t; logic pv;
    d = '{default: 32'd0}; d[0] = 32'd10; d[1] = 32'd20; d[2] = 32'd30; d[3] = 32'd40;
    do_write(32'h8000_0500, 8'd3, 2'b01, 3'd2, 4'd0, d, 4'hF, 3, resp, b);
    araddr = 32'h8000_0500; arlen = 8'd3; arburst = 2'b01; arsize = 3'd2; arvalid = 1;
    t = 0;
    while (!arready && t < 100) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1; arvalid = 0;
    t = 0;
    while (!rvalid && t < 50) begin @(posedge clk); #1; t++; end
    rready = 1;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if ({rvalid, rdata} !== {1'b1, 32'd30}) begin errors++; $display("FAIL midrd_beat2 got v=%b data=%h want 1/1e", rvalid, rdata); end
    rst = 1; rready = 0;
    #1;
    checks++; if ({rvalid, rlast, arready} !== 3'b000) begin errors++; $display("FAIL midrd_async got %b want 000", {rvalid, rlast, arready}); end
    repeat (2) @(posedge clk);
    #1; rst = 0; #1;
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL midrd_arready_release got %b want 0", arready); end
    @(posedge clk); #1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL midrd_arready_edge got %b want 1", arready); end
    do_read(32'h8000_0500, 8'd3, 2'b01, 3'd2, 4'd0, 0, rd, rr, rl, ri, n, lat, cyc, viol, pv);
    checks++; if ({rd[0], rd[1], rd[2], rd[3]} !== {32'd10, 32'd20, 32'd30, 32'd40}) begin errors++;
      $display("FAIL midrd_mem got %h %h %h %h want a 14 1e 28", rd[0], rd[1], rd[2], rd[3]); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_write_read();
    test_rready_throttle();
    test_wstrb();
    test_errors();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
